branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage branch predictor for the RISC-V core. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and predicts the next fetch PC every cycle. It is trained by the resolved outcome of the execute-stage `branchUnit`, whose `zero` output is this block's `exTaken`. It also raises `mispredict` and `redirectPC` so the pipeline can flush and refetch, and it keeps branch/mispredict statistics counters.

## Interface
- `DATA_WIDTH`, 32: PC/target width.
- `INDEX_BITS`, 6: table index width; the table has 2^INDEX_BITS entries.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `fetchPC` in DATA_WIDTH: PC currently being fetched.
- `nextFetchPC` out DATA_WIDTH: PC to fetch next cycle.
- `predictTaken` out 1: fetch-stage prediction; the pipeline carries it to execute.
- `predictTarget` out DATA_WIDTH: predicted target; the pipeline carries it to execute.
- `exBranch` in 1: the execute stage holds a conditional branch this cycle.
- `exPC` in DATA_WIDTH: PC of that branch.
- `exTarget` in DATA_WIDTH: computed branch target.
- `exTaken` in 1: resolved outcome (`branchUnit.zero`).
- `exPredTaken` in 1: `predictTaken` carried with the branch.
- `exPredTarget` in DATA_WIDTH: `predictTarget` carried with the branch.
- `mispredict` out 1: flush request.
- `redirectPC` out DATA_WIDTH: correct PC when `mispredict` is 1.
- `branchCount` out 32: resolved branches since reset.
- `mispredictCount` out 32: mispredicts since reset.

## Operation
- Entry fields: `valid`, `tag` = PC[DATA_WIDTH-1:INDEX_BITS+2], `target`, `ctr[1:0]`. Index = PC[INDEX_BITS+1:2]. PC[1:0] is ignored.
- Table is a flop array, not RAM, so it can be cleared in one cycle.
- Lookup is combinational on `fetchPC`:
  - `hit` = valid && tag match.
  - `predictTaken` = hit && ctr[1].
  - `predictTarget` = hit ? target : fetchPC+4.
- `mispredict` is combinational: exBranch && (exTaken != exPredTaken || (exTaken && exTarget != exPredTarget)).
- `redirectPC` = exTaken ? exTarget : exPC+4.
- `nextFetchPC` = mispredict ? redirectPC : (predictTaken ? predictTarget : fetchPC+4). A mispredict always wins over the fetch prediction.
- Training at the rising edge when rst_n=1 and exBranch=1:
  - Hit at exPC, taken: ctr saturating +1 (max 11), target <= exTarget.
  - Hit at exPC, not taken: ctr saturating -1 (min 00), target unchanged.
  - Miss, taken: allocate (overwrite): valid=1, tag, target=exTarget, ctr=10.
  - Miss, not taken: no write.
- Counters:
  - `branchCount` +1 per exBranch cycle.
  - `mispredictCount` +1 per mispredict cycle.
  - Both saturate at 0xFFFFFFFF and do not wrap.
- PC adds (+4) wrap modulo 2^DATA_WIDTH.

## Timing
- Reset: a rising edge with rst_n=0 clears all valid bits, sets all ctr to 01, and zeroes both counters.
  - Reset overrides any training in that cycle.
  - Reset mid-operation drops the in-flight update.
  - After reset: predictTaken=0, predictTarget=nextFetchPC=fetchPC+4, counts=0. mispredict/redirectPC follow the ex inputs combinationally.
- Prediction latency is 0 cycles from `fetchPC`. Training becomes visible to lookup the cycle after the update edge.
- Same-index read and update in one cycle: the lookup returns the pre-update entry. There is no bypass.
- No handshake. `exBranch` is sampled every cycle, and the upstream stall/flush logic must gate it for bubbles.

## Test plan
- Reset, fetchPC=0x100 -> predictTaken=0, nextFetchPC=0x104, branchCount=mispredictCount=0.
- exBranch=1, exPC=0x100, exTarget=0x80, exTaken=1, exPredTaken=0 -> same cycle mispredict=1, redirectPC=0x80, nextFetchPC=0x80. Next cycle, fetchPC=0x100 -> predictTaken=1, nextFetchPC=0x80, mispredictCount=1, branchCount=1.
- Hysteresis: after the allocate above, one more taken (ctr 11), then one not-taken with exPredTaken=1 -> mispredict=1, redirectPC=0x104. Next cycle, 0x100 still predicts taken (ctr 10). A second not-taken -> predicts not-taken (ctr 01).
- Aliasing: train 0x100 taken, then fetchPC=0x200 (same index, different tag) -> predictTaken=0, nextFetchPC=0x204. A taken 0x200 -> 0x40 replaces the entry, after which 0x100 misses.
- Not-taken miss at 0x300 with exPredTaken=0 -> mispredict=0, no allocation, branchCount+1. Same-cycle fetch of the index being allocated returns the old (miss) result.
- rst_n=0 while exBranch=1 with a taken branch -> no allocation, counts=0 after the edge, all lookups miss.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage BTB branch predictor with 2-bit counters
//
// Direct-mapped branch target buffer held in flops. Lookup on fetchPC is
// combinational; training from the execute-stage resolution happens on the
// rising edge. Also flags mispredicts and keeps saturating statistics.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   fetchPC                         PC being fetched this cycle
//   nextFetchPC                     PC to fetch next cycle
//   predictTaken, predictTarget     fetch prediction, carried down the pipe
//   exBranch, exPC, exTarget        resolved conditional branch in execute
//   exTaken                         resolved outcome
//   exPredTaken, exPredTarget       prediction that travelled with the branch
//   mispredict, redirectPC          flush request and correct refetch PC
//   branchCount, mispredictCount    saturating statistics since reset
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fetchPC,
  output logic [DATA_WIDTH-1:0] nextFetchPC,
  output logic                  predictTaken,
  output logic [DATA_WIDTH-1:0] predictTarget,
  input  logic                  exBranch,
  input  logic [DATA_WIDTH-1:0] exPC,
  input  logic [DATA_WIDTH-1:0] exTarget,
  input  logic                  exTaken,
  input  logic                  exPredTaken,
  input  logic [DATA_WIDTH-1:0] exPredTarget,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirectPC,
  output logic [31:0]           branchCount,
  output logic [31:0]           mispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [DATA_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [1:0]            ctr_d    [ENTRIES];
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic                  f_hit, e_hit;
  logic [DATA_WIDTH-1:0] fetch_plus4, ex_plus4;

  assign f_idx = fetchPC[INDEX_BITS+1:2];
  assign f_tag = fetchPC[DATA_WIDTH-1:INDEX_BITS+2];
  assign e_idx = exPC[INDEX_BITS+1:2];
  assign e_tag = exPC[DATA_WIDTH-1:INDEX_BITS+2];

  assign fetch_plus4 = fetchPC + DATA_WIDTH'(4);
  assign ex_plus4    = exPC + DATA_WIDTH'(4);

  // Lookups read the registered table only, so a same-cycle update is not
  // visible until the following cycle.
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign predictTaken  = f_hit && ctr_q[f_idx][1];
  assign predictTarget = f_hit ? target_q[f_idx] : fetch_plus4;

  // Target only matters when the branch was actually taken.
  assign mispredict = exBranch &&
                      ((exTaken != exPredTaken) ||
                       (exTaken && (exTarget != exPredTarget)));
  assign redirectPC = exTaken ? exTarget : ex_plus4;

  assign nextFetchPC = mispredict   ? redirectPC    :
                       predictTaken ? predictTarget : fetch_plus4;

  assign branchCount     = branch_count_q;
  assign mispredictCount = mispredict_count_q;

  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    target_d           = target_q;
    ctr_d              = ctr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (exBranch) begin
      if (e_hit) begin
        if (exTaken) begin
          if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
          target_d[e_idx] = exTarget;
        end else if (ctr_q[e_idx] != 2'b00) begin
          ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
        end
      end else if (exTaken) begin
        // Allocate weakly taken, overwriting whatever aliases this index.
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = exTarget;
        ctr_d[e_idx]    = 2'b10;
      end
      if (branch_count_q != 32'hFFFF_FFFF)
        branch_count_d = branch_count_q + 32'd1;
    end

    if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q            <= valid_d;
      ctr_q              <= ctr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tag and target are only meaningful behind a valid bit, so they need no
  // reset; the reset edge simply must not load them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetchPC, nextFetchPC, predictTarget;
  logic        predictTaken;
  logic        exBranch, exTaken, exPredTaken;
  logic [31:0] exPC, exTarget, exPredTarget;
  logic        mispredict;
  logic [31:0] redirectPC, branchCount, mispredictCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetchPC(fetchPC), .nextFetchPC(nextFetchPC),
    .predictTaken(predictTaken), .predictTarget(predictTarget),
    .exBranch(exBranch), .exPC(exPC), .exTarget(exTarget),
    .exTaken(exTaken), .exPredTaken(exPredTaken), .exPredTarget(exPredTarget),
    .mispredict(mispredict), .redirectPC(redirectPC),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  typedef struct {
    logic [31:0] fpc, exb, expc, ext, extk, expt, exptgt;
    logic [31:0] nfpc, pt, ptgt, mp, rpc, bc, mc;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fetchPC      = v.fpc;
    exBranch     = v.exb[0];
    exPC         = v.expc;
    exTarget     = v.ext;
    exTaken      = v.extk[0];
    exPredTaken  = v.expt[0];
    exPredTarget = v.exptgt;
  endtask

  initial begin
    //           fpc           exb expc          ext       tk pt ptgt     | nfpc      pt ptgt      mp rpc       bc mc
    vecs[0]  = '{32'h100,      0, 0,            0,        0, 0, 0,        32'h104,  0, 32'h104,  0, 32'h4,    0, 0};
    vecs[1]  = '{32'h100,      1, 32'h100,      32'h80,   1, 0, 0,        32'h80,   0, 32'h104,  1, 32'h80,   0, 0};
    vecs[2]  = '{32'h100,      0, 0,            0,        0, 0, 0,        32'h80,   1, 32'h80,   0, 32'h4,    1, 1};
    vecs[3]  = '{32'h100,      1, 32'h100,      32'h80,   1, 1, 32'h80,   32'h80,   1, 32'h80,   0, 32'h80,   1, 1};
    vecs[4]  = '{32'h100,      1, 32'h100,      32'h80,   0, 1, 32'h80,   32'h104,  1, 32'h80,   1, 32'h104,  2, 1};
    vecs[5]  = '{32'h100,      0, 0,            0,        0, 0, 0,        32'h80,   1, 32'h80,   0, 32'h4,    3, 2};
    vecs[6]  = '{32'h100,      1, 32'h100,      32'h80,   0, 1, 32'h80,   32'h104,  1, 32'h80,   1, 32'h104,  3, 2};
    vecs[7]  = '{32'h100,      0, 0,            0,        0, 0, 0,        32'h104,  0, 32'h80,   0, 32'h4,    4, 3};
    vecs[8]  = '{32'h200,      0, 0,            0,        0, 0, 0,        32'h204,  0, 32'h204,  0, 32'h4,    4, 3};
    vecs[9]  = '{32'h200,      1, 32'h200,      32'h40,   1, 0, 0,        32'h40,   0, 32'h204,  1, 32'h40,   4, 3};
    vecs[10] = '{32'h100,      0, 0,            0,        0, 0, 0,        32'h104,  0, 32'h104,  0, 32'h4,    5, 4};
    vecs[11] = '{32'h200,      0, 0,            0,        0, 0, 0,        32'h40,   1, 32'h40,   0, 32'h4,    5, 4};
    vecs[12] = '{32'h300,      1, 32'h300,      32'h500,  0, 0, 0,        32'h304,  0, 32'h304,  0, 32'h304,  5, 4};
    vecs[13] = '{32'h300,      0, 0,            0,        0, 0, 0,        32'h304,  0, 32'h304,  0, 32'h4,    6, 4};
    vecs[14] = '{32'h200,      0, 0,            0,        0, 0, 0,        32'h40,   1, 32'h40,   0, 32'h4,    6, 4};
    vecs[15] = '{32'h104,      1, 32'h104,      32'h10,   1, 0, 0,        32'h10,   0, 32'h108,  1, 32'h10,   6, 4};
    vecs[16] = '{32'h104,      0, 0,            0,        0, 0, 0,        32'h10,   1, 32'h10,   0, 32'h4,    7, 5};
    vecs[17] = '{32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h20,   0, 1, 32'h20,   32'h0,    0, 32'h0,    1, 32'h0,    7, 5};
    vecs[18] = '{32'h104,      1, 32'h104,      32'h18,   1, 1, 32'h10,   32'h18,   1, 32'h10,   1, 32'h18,   8, 6};
    vecs[19] = '{32'h104,      0, 0,            0,        0, 0, 0,        32'h18,   1, 32'h18,   0, 32'h4,    9, 7};

    rst_n = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #2;
      chk("nextFetchPC",     i, nextFetchPC,           vecs[i].nfpc);
      chk("predictTaken",    i, {31'd0, predictTaken}, vecs[i].pt);
      chk("predictTarget",   i, predictTarget,         vecs[i].ptgt);
      chk("mispredict",      i, {31'd0, mispredict},   vecs[i].mp);
      chk("redirectPC",      i, redirectPC,            vecs[i].rpc);
      chk("branchCount",     i, branchCount,           vecs[i].bc);
      chk("mispredictCount", i, mispredictCount,       vecs[i].mc);
    end

    // Reset edge coinciding with a taken branch at a fresh index.
    @(negedge clk);
    rst_n        = 1'b0;
    fetchPC      = 32'h108;
    exBranch     = 1'b1;
    exPC         = 32'h108;
    exTarget     = 32'h300;
    exTaken      = 1'b1;
    exPredTaken  = 1'b0;
    exPredTarget = 32'h0;
    #2;
    chk("rst_mispredict", 0, {31'd0, mispredict}, 32'd1);
    chk("rst_redirect",   0, redirectPC,          32'h300);

    @(negedge clk);
    rst_n    = 1'b1;
    exBranch = 1'b0;
    #2;
    chk("rst_branchCount",     1, branchCount,           32'd0);
    chk("rst_mispredictCount", 1, mispredictCount,       32'd0);
    chk("rst_pt_108",          1, {31'd0, predictTaken}, 32'd0);
    chk("rst_nfpc_108",        1, nextFetchPC,           32'h10C);
    fetchPC = 32'h200;
    #1;
    chk("rst_pt_200",          2, {31'd0, predictTaken}, 32'd0);
    chk("rst_ptgt_200",        2, predictTarget,         32'h204);
    fetchPC = 32'h104;
    #1;
    chk("rst_pt_104",          3, {31'd0, predictTaken}, 32'd0);
    chk("rst_nfpc_104",        3, nextFetchPC,           32'h108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
